mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-port arbiter in front of a single-ported synchronous word store.
// Each granted access runs IDLE -> WAIT (LATENCY cycles) -> RESP -> IDLE.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN selects round-robin
// arbitration; when it is undefined, fixed priority applies (lowest index wins).
module mem_arbiter #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_PORTS-1:0]          i_req,
  input  logic [N_PORTS-1:0]          i_we,
  input  logic [N_PORTS*ADDR_W-1:0]   i_addr,
  input  logic [N_PORTS*DATA_W-1:0]   i_wdata,
  output logic [N_PORTS-1:0]          o_gnt,
  output logic [N_PORTS-1:0]          o_done,
  output logic [N_PORTS-1:0]          o_err,
  output logic [DATA_W-1:0]           o_rdata,
  output logic                        o_busy
);

  localparam int PW    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [PW-1:0]       w_win;
  logic                w_any;
  logic [PW-1:0]       r_win;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [3:0]          r_cnt;
  logic [DATA_W-1:0]   r_rdata;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_oor;
  logic                w_commit;
  logic [IDX_W-1:0]    w_idx;

  assign w_oor    = ({1'b0, r_addr} >= (ADDR_W+1)'(DEPTH));
  assign w_idx    = r_addr[IDX_W-1:0];
  assign w_commit = (r_state == S_WAIT) && (r_cnt == 4'd1);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [PW-1:0] r_last;

  // Round-robin winner: search starts one past the previous winner.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int unsigned i = 1; i <= N_PORTS; i++) begin
      if (!w_any && i_req[(32'(r_last) + i) % N_PORTS]) begin
        w_win = PW'((32'(r_last) + i) % N_PORTS);
        w_any = 1'b1;
      end
    end
  end

  // Pointer remembers the last granted port; reset so port 0 is searched first.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_last <= PW'(N_PORTS - 1);
    end else if (r_state == S_IDLE && w_any) begin
      r_last <= w_win;
    end
  end
`else
  // Fixed priority winner: lowest requesting index.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (!w_any && i_req[i]) begin
        w_win = PW'(i);
        w_any = 1'b1;
      end
    end
  end
`endif

  // FSM state register; reset returns to IDLE without waiting for a clock.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: arbitration only happens in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_WAIT;
      S_WAIT:  if (r_cnt == 4'd1) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Latch the winner's request at grant and run the wait counter.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_win   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
    end else if (r_state == S_IDLE && w_any) begin
      r_win   <= w_win;
      r_we    <= i_we[w_win];
      r_addr  <= i_addr[w_win*ADDR_W +: ADDR_W];
      r_wdata <= i_wdata[w_win*DATA_W +: DATA_W];
      r_cnt   <= 4'(LATENCY);
    end else if (r_state == S_WAIT) begin
      r_cnt   <= r_cnt - 4'd1;
    end
  end

  // Storage access on the last WAIT edge; no reset so contents survive i_rst.
  // Read data is forced to zero for writes and out-of-range reads here,
  // so the output mux only needs the RESP qualifier.
  always_ff @(posedge i_clk) begin
    if (w_commit) begin
      if (r_we && !w_oor) begin
        r_mem[w_idx] <= r_wdata;
      end
      r_rdata <= (r_we || w_oor) ? '0 : r_mem[w_idx];
    end
  end

  // Output decode: grant on the first WAIT cycle, done/err/rdata in RESP.
  always_comb begin
    o_gnt   = '0;
    o_done  = '0;
    o_err   = '0;
    o_rdata = '0;
    o_busy  = (r_state != S_IDLE);
    if (r_state == S_WAIT && r_cnt == 4'(LATENCY)) begin
      o_gnt[r_win] = 1'b1;
    end
    if (r_state == S_RESP) begin
      o_done[r_win] = 1'b1;
      o_err[r_win]  = w_oor;
      o_rdata       = r_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: a 2-port LATENCY=1 instance and a
// 4-port LATENCY=3 instance, both DEPTH=16 with 8-bit addresses.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: N_PORTS=2, LATENCY=1
  logic        rstA;
  logic [1:0]  reqA, weA, gntA, doneA, errA;
  logic [15:0] addrA;
  logic [63:0] wdataA;
  logic [31:0] rdataA;
  logic        busyA;

  // Instance B: N_PORTS=4, LATENCY=3
  logic         rstB;
  logic [3:0]   reqB, weB, gntB, doneB, errB;
  logic [31:0]  addrB;
  logic [127:0] wdataB;
  logic [31:0]  rdataB;
  logic         busyB;

  mem_arbiter #(.N_PORTS(2), .ADDR_W(8), .DATA_W(32), .DEPTH(16), .LATENCY(1)) u_a (
    .i_clk(clk), .i_rst(rstA), .i_req(reqA), .i_we(weA), .i_addr(addrA),
    .i_wdata(wdataA), .o_gnt(gntA), .o_done(doneA), .o_err(errA),
    .o_rdata(rdataA), .o_busy(busyA)
  );

  mem_arbiter #(.N_PORTS(4), .ADDR_W(8), .DATA_W(32), .DEPTH(16), .LATENCY(3)) u_b (
    .i_clk(clk), .i_rst(rstB), .i_req(reqB), .i_we(weB), .i_addr(addrB),
    .i_wdata(wdataB), .o_gnt(gntB), .o_done(doneB), .o_err(errB),
    .o_rdata(rdataB), .o_busy(busyB)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full access on instance A starting from IDLE.
  task automatic a_txn(input int p, input logic we, input logic [7:0] addr,
                       input logic [31:0] d, input logic [31:0] exp_rd, input string tag);
    reqA[p] = 1'b1;
    weA[p]  = we;
    addrA[p*8 +: 8]   = addr;
    wdataA[p*32 +: 32] = d;
    tick;
    chk({tag, "_gnt"},  gntA, 2'b01 << p);
    chk({tag, "_busy"}, busyA, 1'b1);
    chk({tag, "_rd0"},  rdataA, 32'h0);
    // Changes after the grant edge must not affect this access.
    reqA[p] = 1'b0;
    addrA[p*8 +: 8]    = ~addr;
    wdataA[p*32 +: 32] = ~d;
    weA[p] = ~we;
    tick;
    chk({tag, "_done"},  doneA, 2'b01 << p);
    chk({tag, "_err"},   errA, 2'b00);
    chk({tag, "_rdata"}, rdataA, exp_rd);
    chk({tag, "_gnt0"},  gntA, 2'b00);
    tick;
    chk({tag, "_idle"},  busyA, 1'b0);
    chk({tag, "_rdz"},   rdataA, 32'h0);
  endtask

  // One full access on instance B (LATENCY=3) starting from IDLE.
  task automatic b_txn(input int p, input logic we, input logic [7:0] addr,
                       input logic [31:0] d, input logic [31:0] exp_rd,
                       input logic exp_err, input string tag);
    reqB[p] = 1'b1;
    weB[p]  = we;
    addrB[p*8 +: 8]     = addr;
    wdataB[p*32 +: 32]  = d;
    tick;
    chk({tag, "_gnt"}, gntB, 4'b0001 << p);
    reqB[p] = 1'b0;
    tick;
    tick;
    chk({tag, "_nodone"}, doneB, 4'b0000);
    tick;
    chk({tag, "_done"},  doneB, 4'b0001 << p);
    chk({tag, "_err"},   errB, exp_err ? (4'b0001 << p) : 4'b0000);
    chk({tag, "_rdata"}, rdataB, exp_rd);
    tick;
    chk({tag, "_idle"},  busyB, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] expg;
    rstA = 1'b0; rstB = 1'b0;
    reqA = '0; weA = '0; addrA = '0; wdataA = '0;
    reqB = '0; weB = '0; addrB = '0; wdataB = '0;
    #1;
    chk("rst_gnt",   gntA, 2'b00);
    chk("rst_done",  doneA, 2'b00);
    chk("rst_err",   errA, 2'b00);
    chk("rst_rdata", rdataA, 32'h0);
    chk("rst_busy",  busyA, 1'b0);
    chk("rst_busyB", busyB, 1'b0);
    tick;
    tick;
    rstA = 1'b1; rstB = 1'b1;

    // Write then read back on port 0, LATENCY=1.
    a_txn(0, 1'b1, 8'd5, 32'hDEADBEEF, 32'h0, "wr5");
    a_txn(0, 1'b0, 8'd5, 32'h0, 32'hDEADBEEF, "rd5");

    // Reset during WAIT aborts an uncommitted write.
    a_txn(0, 1'b1, 8'd7, 32'h11111111, 32'h0, "wr7a");
    reqA[0] = 1'b1; weA[0] = 1'b1; addrA[7:0] = 8'd7; wdataA[31:0] = 32'h22222222;
    tick;
    chk("abort_gnt", gntA, 2'b01);
    reqA[0] = 1'b0;
    rstA = 1'b0;
    #1;
    chk("abort_busy", busyA, 1'b0);
    chk("abort_gnt0", gntA, 2'b00);
    tick;
    chk("abort_done", doneA, 2'b00);
    rstA = 1'b1;
    tick;
    chk("abort_done2", doneA, 2'b00);
    chk("abort_idle", busyA, 1'b0);
    a_txn(0, 1'b0, 8'd7, 32'h0, 32'h11111111, "rd7");

    // Both ports hold read requests continuously, pointer freshly reset.
    rstA = 1'b0;
    tick;
    rstA = 1'b1;
    reqA = 2'b11; weA = 2'b00; addrA = {8'd5, 8'd5};
    for (int k = 0; k < 4; k++) begin
      int n;
      n = 0;
      do begin
        tick;
        n++;
      end while (gntA == 2'b00 && n < 10);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      expg = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      expg = 2'b01;
`endif
      chk("both_gnt", gntA, expg);
      if (k > 0) chk("both_period", 32'(n), 32'd3);
    end
    reqA = 2'b00;
    tick;
    chk("both_done_rdata", rdataA, 32'hDEADBEEF);
    tick;
    tick;

    // Instance B: out-of-range write ignored, out-of-range read errors.
    b_txn(2, 1'b1, 8'd5,  32'hA5A5A5A5, 32'h0, 1'b0, "bwr5");
    b_txn(2, 1'b1, 8'd21, 32'hFFFF0000, 32'h0, 1'b1, "bwr_oor");
    b_txn(2, 1'b0, 8'd5,  32'h0, 32'hA5A5A5A5, 1'b0, "brd5");
    b_txn(1, 1'b0, 8'd18, 32'h0, 32'h0, 1'b1, "brd_oor");

    // Requests arriving while busy wait for IDLE, then 1 before 3.
    reqB = 4'b0001; weB = 4'b0000; addrB = {8'd5, 8'd5, 8'd5, 8'd5};
    tick;
    chk("busy_gnt0", gntB, 4'b0001);
    reqB = 4'b1010;
    tick;
    chk("busy_hold1", gntB, 4'b0000);
    tick;
    chk("busy_hold2", gntB, 4'b0000);
    tick;
    chk("busy_done0", doneB, 4'b0001);
    chk("busy_hold3", gntB, 4'b0000);
    tick;
    chk("busy_idle_gnt", gntB, 4'b0000);
    chk("busy_idle", busyB, 1'b0);
    tick;
    chk("busy_gnt1", gntB, 4'b0010);
    reqB = 4'b1000;
    tick;
    tick;
    tick;
    chk("busy_done1", doneB, 4'b0010);
    chk("busy_rdata1", rdataB, 32'hA5A5A5A5);
    tick;
    tick;
    chk("busy_gnt3", gntB, 4'b1000);
    reqB = 4'b0000;
    tick;
    tick;
    tick;
    chk("busy_done3", doneB, 4'b1000);
    tick;
    chk("busy_end", busyB, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
